// File: rtl/pio_pkg.sv
// Shared register-map and edge-type constants for the parametrised PIO input port.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE    = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: SYNC_STAGES-deep synchronizer, plus a stability filter when
// PIO_DEBOUNCE_EN is defined (otherwise the level is the synchronized input).
module pio_debounce_bit
  import pio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef PIO_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // The level only follows sync_in after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_sync != r_level) begin
      if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= w_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_level = r_level;
`else
  assign o_level = w_sync;
`endif

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with per-bit edge capture (W1C), interrupt mask and level IRQ.
// Optional input debouncing is built when PIO_DEBOUNCE_EN is defined.
module pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_MAX = PRIME_W'(SYNC_STAGES + 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_chk_width
    $error("pio_in_edge_irq: WIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_sync
    $error("pio_in_edge_irq: SYNC_STAGES must be 2..4");
  end
  if (EDGE_TYPE != EDGE_RISE && EDGE_TYPE != EDGE_FALL && EDGE_TYPE != EDGE_ANY) begin : g_chk_edge
    $error("pio_in_edge_irq: EDGE_TYPE must be 0, 1 or 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
    $error("pio_in_edge_irq: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [WIDTH-1:0]   w_level;
  logic [WIDTH-1:0]   w_rise;
  logic [WIDTH-1:0]   w_fall;
  logic [WIDTH-1:0]   w_edge_raw;
  logic [WIDTH-1:0]   w_edge_evt;
  logic [WIDTH-1:0]   w_clr;
  logic [31:0]        w_rd_mux;
  logic               w_wr;
  logic               w_primed;
  logic               w_unused_wdata;

  logic [PRIME_W-1:0] r_prime_cnt;
  logic [WIDTH-1:0]   r_prev;
  logic [WIDTH-1:0]   r_irqmask;
  logic [WIDTH-1:0]   r_edgecap;
  logic [31:0]        r_readdata;
  logic               r_irq;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    pio_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES)
`ifdef PIO_DEBOUNCE_EN
      , .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .i_async (in_port[gi]),
      .o_level (w_level[gi])
    );
  end

  // A write is a single-cycle strobe: chipselect high and write_n low; reads need no strobe.
  assign w_wr           = chipselect & ~write_n;
  assign w_clr          = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
  assign w_unused_wdata = ^writedata;
  assign w_primed       = (r_prime_cnt == PRIME_MAX);

  assign w_rise = w_level & ~r_prev;
  assign w_fall = ~w_level & r_prev;

  always_comb begin
    w_edge_raw = w_rise | w_fall;
    if (EDGE_TYPE == EDGE_RISE) begin
      w_edge_raw = w_rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      w_edge_raw = w_fall;
    end
    w_edge_evt = w_primed ? w_edge_raw : '0;
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_level;
      ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_irqmask;
      ADDR_EDGE:    w_rd_mux[WIDTH-1:0] = r_edgecap;
      default:      w_rd_mux = '0;
    endcase
  end

  // Edges are ignored until the synchronizer has flushed its reset zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prime_cnt <= '0;
      r_prev      <= '0;
    end else begin
      if (!w_primed) begin
        r_prime_cnt <= r_prime_cnt + PRIME_W'(1);
      end
      r_prev <= w_level;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irqmask  <= '0;
      r_edgecap  <= '0;
      r_irq      <= 1'b0;
      r_readdata <= '0;
    end else begin
      if (w_wr && address == ADDR_IRQMASK) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
      r_edgecap  <= w_edge_evt | (r_edgecap & ~w_clr);
      r_irq      <= |(r_edgecap & r_irqmask);
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed bench for pio_in_edge_irq: default rising-edge port, a falling-edge
// port and an 8-bit any-edge port share one bus with separate chipselects.
module tb_pio_in_edge_irq;

`ifdef PIO_DEBOUNCE_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 0;
`endif
  localparam int SETTLE = 6 + LAT;
  localparam logic [31:0] EC_INIT = (LAT > 0) ? 32'h3 : 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        cs_a, cs_b, cs_c;
  logic [1:0]  in_a, in_c;
  logic [7:0]  in_b;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pio_in_edge_irq dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_a), .write_n(write_n),
    .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a)
  );

  pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_b), .write_n(write_n),
    .writedata(writedata), .in_port(in_b), .readdata(rd_b), .irq(irq_b)
  );

  pio_in_edge_irq #(.EDGE_TYPE(1)) dut_c (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_c), .write_n(write_n),
    .writedata(writedata), .in_port(in_c), .readdata(rd_c), .irq(irq_c)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // sel = {cs_c, cs_b, cs_a}; the write lands on the first clock edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [2:0] sel);
    address   = a;
    writedata = d;
    {cs_c, cs_b, cs_a} = sel;
    write_n   = 1'b0;
    tick(1);
    write_n   = 1'b1;
    {cs_c, cs_b, cs_a} = 3'b000;
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; write_n = 1'b1; writedata = '0;
    cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0;
    in_a = 2'b11; in_b = 8'h00; in_c = 2'b11;
    tick(3);
    check("reset_readdata", rd_a, 32'h0);
    check("reset_irq", {31'b0, irq_a}, 32'h0);

    // Inputs already high at release must not look like an edge.
    reset = 1'b0;
    tick(3 + LAT);
    check("prime_data", rd_a, 32'h3);
    address = 2'd3;
    tick(1);
    check("prime_edge", rd_a, EC_INIT);
    check("prime_irq", {31'b0, irq_a}, 32'h0);
    check("prime_edge_fall", rd_c, 32'h0);

    // Rising edge on bit1, exact capture latency, then W1C.
    bus_write(2'd3, 32'h3, 3'b001);
    in_a = 2'b01;
    tick(SETTLE);
    tick(1);
    check("fall_not_captured", rd_a, 32'h0);
    in_a = 2'b11;
    tick(3 + LAT);
    check("rise_b1_early", rd_a, 32'h0);
    tick(1);
    check("rise_b1", rd_a, 32'h2);
    bus_write(2'd3, 32'h2, 3'b001);
    tick(1);
    check("w1c_b1", rd_a, 32'h0);

    // Interrupt assert and mask-driven deassert.
    bus_write(2'd2, 32'h1, 3'b001);
    tick(1);
    check("irqmask_rd", rd_a, 32'h1);
    address = 2'd3;
    in_a = 2'b10;
    tick(SETTLE);
    check("irq_idle", {31'b0, irq_a}, 32'h0);
    in_a = 2'b11;
    tick(3 + LAT);
    check("irq_before", {31'b0, irq_a}, 32'h0);
    tick(1);
    check("irq_set", {31'b0, irq_a}, 32'h1);
    check("edge_b0", rd_a, 32'h1);
    bus_write(2'd2, 32'h0, 3'b001);
    check("irq_hold_mask_edge", {31'b0, irq_a}, 32'h1);
    tick(1);
    check("irq_masked", {31'b0, irq_a}, 32'h0);
    address = 2'd3;
    tick(1);
    check("edge_kept", rd_a, 32'h1);

    // Edge and W1C on the same cycle: the edge wins.
    bus_write(2'd3, 32'h1, 3'b001);
    tick(1);
    check("w1c_b0", rd_a, 32'h0);
    in_a = 2'b10;
    tick(SETTLE);
    in_a = 2'b11;
    tick(2 + LAT);
    bus_write(2'd3, 32'h1, 3'b001);
    tick(1);
    check("edge_beats_clr", rd_a, 32'h1);
    bus_write(2'd3, 32'h1, 3'b001);
    tick(1);
    check("clr_alone", rd_a, 32'h0);

    // Re-arm an interrupt, then check the reserved address and an async reset.
    in_a = 2'b10;
    tick(SETTLE);
    in_a = 2'b11;
    tick(SETTLE);
    bus_write(2'd2, 32'h1, 3'b001);
    tick(2);
    check("irq_rearm", {31'b0, irq_a}, 32'h1);
    address = 2'd1;
    tick(1);
    check("reserved_rd", rd_a, 32'h0);
    address = 2'd3;
    tick(1);
    reset = 1'b1;
    #2;
    check("midreset_rd", rd_a, 32'h0);
    check("midreset_irq", {31'b0, irq_a}, 32'h0);
    tick(2);
    reset = 1'b0;
    address = 2'd0;
    tick(3 + LAT);
    check("reprime_data", rd_a, 32'h3);
    address = 2'd2;
    tick(1);
    check("reprime_mask", rd_a, 32'h0);
    address = 2'd3;
    tick(1);
    check("reprime_edge", rd_a, EC_INIT);

    // Falling-edge port.
    in_c = 2'b01;
    tick(3 + LAT);
    check("fall_early", rd_c, 32'h0);
    tick(1);
    check("fall_b1", rd_c, 32'h2);

    // 8-bit any-edge port.
    in_b = 8'hA5;
    tick(4 + LAT);
    check("any_rise", rd_b, 32'hA5);
    bus_write(2'd3, 32'hFF, 3'b010);
    tick(1);
    check("any_w1c", rd_b, 32'h0);
    in_b = 8'h00;
    tick(4 + LAT);
    check("any_fall", rd_b, 32'hA5);
    address = 2'd0;
    tick(1);
    check("any_data", rd_b, 32'h0);
    check("any_irq", {31'b0, irq_b}, 32'h0);

`ifdef PIO_DEBOUNCE_EN
    bus_write(2'd3, 32'hFF, 3'b010);
    address = 2'd0;
    in_b = 8'h01;
    tick(10);
    in_b = 8'h00;
    tick(SETTLE);
    check("glitch_data", rd_b, 32'h0);
    address = 2'd3;
    tick(1);
    check("glitch_edge", rd_b, 32'h0);
    address = 2'd0;
    in_b = 8'h01;
    tick(18);
    check("deb_data_early", rd_b, 32'h0);
    tick(1);
    check("deb_data", rd_b, 32'h1);
    tick(1);
    in_b = 8'h00;
    tick(SETTLE);
    address = 2'd3;
    tick(1);
    check("deb_edge", rd_b, 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pio_in_edge_irq.md
Name: pio_in_edge_irq

Overview:
- Parametrised Avalon-MM slave input port, the successor to the fixed 2-bit key PIO.
- Samples WIDTH asynchronous board inputs (keys/switches) through a synchronizer.
- Provides per-bit edge capture with write-1-to-clear, a per-bit interrupt mask and a level interrupt to the Nios II IRQ line.
- Sits between board pins and the SoC interconnect; the CPU reads the level, polls or clears edges, and enables interrupts.

Parameters:
- WIDTH, 2: number of input bits (1..32).
- SYNC_STAGES, 2: synchronizer flip-flop depth (2..4).
- EDGE_TYPE, 0: captured edge; 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a level is accepted. Used only with PIO_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset. All flops clear on reset assertion.
- Reset values:
  - readdata = 0, irq = 0.
  - irqmask = 0, edgecapture = 0.
  - Sync chain = 0, previous-level register = 0.
  - Prime counter = 0.
- Input path:
  - in_port passes through SYNC_STAGES flops to give sync_in.
  - Without PIO_DEBOUNCE_EN, level = sync_in.
- Priming:
  - A prime counter counts up from 0 after reset release and saturates at SYNC_STAGES+1.
  - Edge detection is suppressed until the counter saturates. This prevents false edges when inputs are already high at reset.
- Edge detect:
  - prev <= level every cycle.
  - rise = level & ~prev; fall = ~level & prev.
  - edge_evt is selected by EDGE_TYPE (rise, fall, or rise|fall), gated by primed.
- Register map (readdata is registered, 1-cycle latency, unused bits 0; reads have no side effects):
  - Address 0, data: readdata = level, zero-extended. Writes are ignored.
  - Address 1, reserved: reads 0, writes ignored.
  - Address 2, irqmask: read/write, writedata[WIDTH-1:0].
  - Address 3, edgecapture: reads the captured bits. A write clears every bit whose writedata bit is 1 (write-1-to-clear).
- Edgecapture update per bit: ec <= edge_evt | (ec & ~clr).
  - If an edge and a clear hit the same bit in the same cycle, the edge wins and the bit stays 1.
- Interrupt:
  - irq is registered: irq <= |(edgecapture & irqmask).
  - irq therefore asserts 1 cycle after edgecapture sets while its mask bit is 1.
  - irq deasserts 1 cycle after the clear or mask write.
- readdata:
  - Updated every cycle from the mux on address; no chipselect gating on reads.
  - readdata is 0 whenever address is 1 (reserved).
- Latency: an in_port transition reaches edgecapture SYNC_STAGES+1 cycles later, plus DEBOUNCE_CYCLES when debouncing is enabled.
- Reset asserted mid-operation: every register clears immediately, and priming restarts after release.

Optional Feature:
- Macro: PIO_DEBOUNCE_EN.
- When defined:
  - Each bit has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - If sync_in differs from level, the counter increments; otherwise it resets to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, level takes sync_in and the counter resets.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never reach level or edgecapture.
  - The debounced level register resets to 0.
- When undefined: no counters are built and level = sync_in.

Decomposition:
- Package pio_pkg holds:
  - Address constants: ADDR_DATA=2'd0, ADDR_IRQMASK=2'd2, ADDR_EDGE=2'd3.
  - Edge-type constants: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- Sub-module pio_debounce_bit: one-bit synchronizer plus optional debounce, instantiated WIDTH times by generate.
- Edge logic and the register file stay in the top module.

Test Plan:
- Reset with in_port=2'b11 held, then release: after 3 cycles data reads 0x3, edgecapture reads 0x0, irq=0.
- EDGE_TYPE=0, in_port bit1 0->1: edgecapture=0x2 after 3 cycles; write 0x2 to address 3 gives edgecapture=0x0.
- irqmask=0x1, bit0 rising edge: irq=1 one cycle after capture; mask write of 0 gives irq=0 next cycle while edgecapture stays 0x1.
- Same-cycle bit0 edge and W1C 0x1: edgecapture bit0 remains 1.
- PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16:
  - A 10-cycle pulse on bit0 leaves data 0x0 and no capture.
  - A 20-cycle pulse raises data and capture exactly 16 cycles after sync_in changes.
- WIDTH=8, EDGE_TYPE=2, in_port toggles 0x00->0xA5->0x00: edgecapture=0xA5 after the first toggle; after W1C 0xFF and the second toggle, edgecapture=0xA5 again.
